bus_arbiter: RTL and testbench

//   Two-master arbiter for the single peripheral/DRAM bus port that feeds the address-decode bridge.

---
 rtl/bus_arbiter_if.sv | 39 +++
 rtl/bus_arbiter.sv | 128 ++++++++++++
 tb/tb_bus_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Purpose : signal bundle between the two bus masters, the arbiter and the
//           address-decode bridge.
// Modports: master - requester side (drives req/lock/addr/we/wdata/bus_rdata,
//                    observes grants, broadcast read data and bus outputs)
//           slave  - arbiter side (consumes requests, drives grants and bus)
interface bus_arbiter_if;
    logic        m0_req;
    logic        m0_lock;
    logic [31:0] m0_addr;
    logic        m0_we;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic        m1_req;
    logic        m1_lock;
    logic [31:0] m1_addr;
    logic        m1_we;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic [31:0] m_rdata;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic [1:0]  bus_owner;

    modport master (
        output m0_req, m0_lock, m0_addr, m0_we, m0_wdata,
        output m1_req, m1_lock, m1_addr, m1_we, m1_wdata,
        output bus_rdata,
        input  m0_gnt, m1_gnt, m_rdata, bus_addr, bus_we, bus_wdata, bus_owner
    );

    modport slave (
        input  m0_req, m0_lock, m0_addr, m0_we, m0_wdata,
        input  m1_req, m1_lock, m1_addr, m1_we, m1_wdata,
        input  bus_rdata,
        output m0_gnt, m1_gnt, m_rdata, bus_addr, bus_we, bus_wdata, bus_owner
    );
endinterface

// File: rtl/bus_arbiter.sv
// Purpose : two-master round-robin arbiter for the shared peripheral/DRAM bus
//           port. Registered grants, burst cap of MAX_BURST cycles while the
//           other master waits, optional owner lock.
// Ports   : clk  - rising-edge clock
//           rst  - synchronous active-high reset
//           bus  - bus_arbiter_if.slave (master requests in, grants and
//                  bridge-side bus signals out, read data broadcast)
//
// state | meaning
// IDLE  | nobody owns the bus, bus outputs forced to 0
// OWN0  | master 0 (CPU data port) owns the bus
// OWN1  | master 1 (DMA/debug loader) owns the bus
module bus_arbiter #(
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 4
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.slave  bus
);

    // Encoding doubles as the bus_owner value.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_last;
    logic             w_last_nxt;

    // Owner-relative view so OWN0 and OWN1 share one set of rules.
    logic w_own_is1;
    logic w_own_req;
    logic w_own_lock;
    logic w_oth_req;

    assign w_own_is1  = (r_state == OWN1);
    assign w_own_req  = w_own_is1 ? bus.m1_req  : bus.m0_req;
    assign w_own_lock = w_own_is1 ? bus.m1_lock : bus.m0_lock;
    assign w_oth_req  = w_own_is1 ? bus.m0_req  : bus.m1_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;    // m0 wins the first tie after reset
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (bus.m0_req && bus.m1_req) begin
                    w_state_nxt = r_last ? OWN0 : OWN1;
                    w_last_nxt  = ~r_last;
                end else if (bus.m0_req) begin
                    w_state_nxt = OWN0;
                    w_last_nxt  = 1'b0;
                end else if (bus.m1_req) begin
                    w_state_nxt = OWN1;
                    w_last_nxt  = 1'b1;
                end
            end
            OWN0, OWN1: begin
                if (!w_own_req) begin
                    w_cnt_nxt = '0;
                    if (w_oth_req) begin
                        w_state_nxt = w_own_is1 ? OWN0 : OWN1;
                        w_last_nxt  = ~w_own_is1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_oth_req && (r_cnt == CNT_LAST) && !w_own_lock) begin
                    // burst cap reached with the other master waiting
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_own_is1 ? OWN0 : OWN1;
                    w_last_nxt  = ~w_own_is1;
                end else if (r_cnt != CNT_LAST) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.m0_gnt    = (r_state == OWN0);
    assign bus.m1_gnt    = (r_state == OWN1);
    assign bus.bus_owner = r_state;
    assign bus.m_rdata   = bus.bus_rdata;

    always_comb begin
        bus.bus_addr  = '0;
        bus.bus_wdata = '0;
        bus.bus_we    = 1'b0;
        case (r_state)
            OWN0: begin
                bus.bus_addr  = bus.m0_addr;
                bus.bus_wdata = bus.m0_wdata;
                bus.bus_we    = bus.m0_we & bus.m0_req;   // no write on the release cycle
            end
            OWN1: begin
                bus.bus_addr  = bus.m1_addr;
                bus.bus_wdata = bus.m1_wdata;
                bus.bus_we    = bus.m1_we & bus.m1_req;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
    localparam int MAX_BURST = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    // Reference model: owner (-1 idle, 0, 1), cycles held in current tenure, last owner.
    int   m_own;
    int   m_run;
    int   m_last;

    bus_arbiter_if u_if ();

    bus_arbiter #(.MAX_BURST(MAX_BURST), .CNT_W(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        logic rq [2];
        logic lk [2];
        int   nxt;
        int   o;
        int   t;
        rq[0] = u_if.m0_req;  rq[1] = u_if.m1_req;
        lk[0] = u_if.m0_lock; lk[1] = u_if.m1_lock;
        if (rst) begin
            m_own = -1; m_run = 0; m_last = 1;
            return;
        end
        if (m_own < 0) begin
            if (rq[0] && rq[1]) nxt = 1 - m_last;
            else if (rq[0])     nxt = 0;
            else if (rq[1])     nxt = 1;
            else                nxt = -1;
        end else begin
            o = m_own; t = 1 - o;
            if (!rq[o])                                   nxt = rq[t] ? t : -1;
            else if (rq[t] && !lk[o] && m_run >= MAX_BURST) nxt = t;
            else                                          nxt = o;
        end
        if (nxt < 0)           m_run = 0;
        else if (nxt != m_own) begin m_run = 1; m_last = nxt; end
        else                   m_run++;
        m_own = nxt;
    endtask

    task automatic check_model();
        logic [31:0] ea;
        logic [31:0] ed;
        logic        ew;
        ea = 32'h0; ed = 32'h0; ew = 1'b0;
        if (m_own == 0) begin
            ea = u_if.m0_addr; ed = u_if.m0_wdata; ew = u_if.m0_we & u_if.m0_req;
        end else if (m_own == 1) begin
            ea = u_if.m1_addr; ed = u_if.m1_wdata; ew = u_if.m1_we & u_if.m1_req;
        end
        chk("gnt0",  {31'b0, u_if.m0_gnt}, {31'b0, (m_own == 0)});
        chk("gnt1",  {31'b0, u_if.m1_gnt}, {31'b0, (m_own == 1)});
        chk("owner", {30'b0, u_if.bus_owner},
            (m_own == 0) ? 32'd1 : (m_own == 1) ? 32'd2 : 32'd0);
        chk("bus_we",    {31'b0, u_if.bus_we}, {31'b0, ew});
        chk("bus_addr",  u_if.bus_addr, ea);
        chk("bus_wdata", u_if.bus_wdata, ed);
        chk("m_rdata",   u_if.m_rdata, u_if.bus_rdata);
    endtask

    // Inputs are set before calling; checks run mid-cycle, then the edge advances the model.
    task automatic cyc();
        #1;
        check_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_m(input int m, input logic req, input logic lock, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (m == 0) begin
            u_if.m0_req = req; u_if.m0_lock = lock; u_if.m0_we = we;
            u_if.m0_addr = addr; u_if.m0_wdata = wdata;
        end else begin
            u_if.m1_req = req; u_if.m1_lock = lock; u_if.m1_we = we;
            u_if.m1_addr = addr; u_if.m1_wdata = wdata;
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        m_own = -1; m_run = 0; m_last = 1;
        rst = 1'b1;
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        u_if.bus_rdata = 32'h0;

        // reset state
        cyc(); cyc();
        chk("rst_gnt", {30'b0, u_if.m1_gnt, u_if.m0_gnt}, 32'd0);
        chk("rst_owner", {30'b0, u_if.bus_owner}, 32'd0);
        chk("rst_we", {31'b0, u_if.bus_we}, 32'd0);
        chk("rst_addr", u_if.bus_addr, 32'd0);
        rst = 1'b0;

        // single m0 write
        set_m(0, 1'b1, 1'b0, 1'b1, 32'hFFFFF060, 32'h5);
        cyc();
        chk("t1_gnt0", {31'b0, u_if.m0_gnt}, 32'd1);
        chk("t1_we", {31'b0, u_if.bus_we}, 32'd1);
        chk("t1_addr", u_if.bus_addr, 32'hFFFFF060);
        chk("t1_wdata", u_if.bus_wdata, 32'h5);
        set_m(0, 1'b0, 1'b0, 1'b1, 32'hFFFFF060, 32'h5);
        #1;
        chk("t1_release_we", {31'b0, u_if.bus_we}, 32'd0);
        cyc();

        // tie after reset goes to m0, tie after an m0 tenure goes to m1
        rst = 1'b1; cyc(); rst = 1'b0;
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
        cyc();
        chk("t2_first_m0", {30'b0, u_if.m1_gnt, u_if.m0_gnt}, 32'd1);
        u_if.m0_req = 1'b0; u_if.m1_req = 1'b0;
        cyc();
        chk("t2_idle", {30'b0, u_if.bus_owner}, 32'd0);
        u_if.m0_req = 1'b1; u_if.m1_req = 1'b1;
        cyc();
        chk("t2_first_m1", {30'b0, u_if.m1_gnt, u_if.m0_gnt}, 32'd2);

        // both held: 8-cycle alternation, m1 started at i=0
        for (int i = 1; i < 32; i++) begin
            cyc();
            chk("t3_alt", {30'b0, u_if.m1_gnt, u_if.m0_gnt},
                (((i / MAX_BURST) % 2) == 0) ? 32'd2 : 32'd1);
        end

        // lock holds off m1 indefinitely while m0 keeps requesting
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
        cyc();
        u_if.m1_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("t4_locked", {30'b0, u_if.m1_gnt, u_if.m0_gnt}, 32'd1);
        end
        u_if.m0_req = 1'b0; u_if.m0_lock = 1'b0;
        cyc();
        chk("t4_handoff", {30'b0, u_if.m1_gnt, u_if.m0_gnt}, 32'd2);

        // reset mid-burst while m1 writes
        set_m(1, 1'b1, 1'b0, 1'b1, 32'hABC0, 32'hDEAD);
        cyc();
        chk("t5_pre_we", {31'b0, u_if.bus_we}, 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("t5_gnt", {30'b0, u_if.m1_gnt, u_if.m0_gnt}, 32'd0);
        chk("t5_we", {31'b0, u_if.bus_we}, 32'd0);
        chk("t5_addr", u_if.bus_addr, 32'd0);

        // m1 read, rdata broadcast
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        u_if.bus_rdata = 32'h1234ABCD;
        cyc();
        chk("t6_gnt1", {31'b0, u_if.m1_gnt}, 32'd1);
        chk("t6_rdata", u_if.m_rdata, 32'h1234ABCD);
        chk("t6_we", {31'b0, u_if.bus_we}, 32'd0);
        chk("t6_addr", u_if.bus_addr, 32'h10);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            set_m(0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 1'($urandom),
                  $urandom, $urandom);
            set_m(1, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 1'($urandom),
                  $urandom, $urandom);
            u_if.bus_rdata = $urandom;
            cyc();
        end
        rst = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
